// File: rtl/mmu_store_encode_if.sv
// -----------------------------------------------------------------------------
// mmu_store_encode_if
// Bundles the store-request handshake (pipeline stage 3 side) and the physical
// write-beat port (memory side) of the store encoder.
//   req_valid/req_ready     : request handshake
//   req_addr/req_data       : byte address and right-justified store data
//   req_size                : 00 byte, 01 half, 10 word, 11 illegal
//   phys_we/phys_ready      : write-beat handshake
//   phys_addr               : word address of the beat
//   phys_data/phys_byte_en  : lane-aligned data and byte-lane enables
//   size_err                : one-cycle pulse on an accepted illegal size
// modport slave  : the encoder itself
// modport master : the surrounding pipeline / memory model
// -----------------------------------------------------------------------------
interface mmu_store_encode_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        phys_we;
    logic [29:0] phys_addr;
    logic [31:0] phys_data;
    logic [3:0]  phys_byte_en;
    logic        phys_ready;
    logic        size_err;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, phys_ready,
        output req_ready, phys_we, phys_addr, phys_data, phys_byte_en, size_err
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, phys_ready,
        input  req_ready, phys_we, phys_addr, phys_data, phys_byte_en, size_err
    );
endinterface

// File: rtl/mmu_store_encode.sv
// -----------------------------------------------------------------------------
// mmu_store_encode
// Store-side byte encoder. Rotates store data into memory byte lanes, builds
// byte enables, and splits word-crossing stores into two word-aligned beats.
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   clk_enable : global pipeline enable; 0 freezes state and masks handshakes
//   bus        : request + physical beat signals (mmu_store_encode_if.slave)
// -----------------------------------------------------------------------------
module mmu_store_encode (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_enable,
    mmu_store_encode_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;

    logic [1:0]  r_state, w_state_next;
    logic        r_phys_we, w_phys_we_next;
    logic [29:0] r_phys_addr, w_phys_addr_next;
    logic [31:0] r_phys_data, w_phys_data_next;
    logic [3:0]  r_phys_byte_en, w_phys_byte_en_next;
    logic [3:0]  r_hi_en, w_hi_en_next;       // lanes for the second beat
    logic        r_size_err, w_size_err_next;

    logic [1:0]  w_align;
    logic [31:0] w_rot_data;
    logic [3:0]  w_base_mask;
    logic [7:0]  w_wide_mask;
    logic        w_size_illegal;
    logic        w_final_beat;
    logic        w_req_ready;
    logic        w_accept;
    logic        w_load;
    logic        w_beat_done;

    assign w_align        = bus.req_addr[1:0];
    assign w_size_illegal = (bus.req_size == 2'b11);

    // Lane gi receives source byte (gi - align) mod 4: a left rotate by 8*align.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            logic [1:0] w_src;
            assign w_src = 2'(gi) - w_align;
            assign w_rot_data[8*gi +: 8] = bus.req_data[{w_src, 3'b000} +: 8];
        end
    endgenerate

    always_comb begin
        w_base_mask = 4'b0000;
        case (bus.req_size)
            2'b00:   w_base_mask = 4'b0001;
            2'b01:   w_base_mask = 4'b0011;
            2'b10:   w_base_mask = 4'b1111;
            default: w_base_mask = 4'b0000;
        endcase
    end

    // Upper nibble holds the lanes that spill into the next word.
    assign w_wide_mask = {4'b0000, w_base_mask} << w_align;

    // A beat is final when no second beat is pending behind it.
    assign w_final_beat = ((r_state == ST_BEAT0) && (r_hi_en == 4'b0000)) ||
                          (r_state == ST_BEAT1);
    assign w_req_ready  = (r_state == ST_IDLE) || (w_final_beat && bus.phys_ready);

    assign w_accept    = clk_enable && bus.req_valid && w_req_ready;
    assign w_load      = w_accept && !w_size_illegal;
    // phys_we is high exactly when a beat is outstanding (BEAT0/BEAT1).
    assign w_beat_done = clk_enable && r_phys_we && bus.phys_ready;

    always_comb begin
        w_state_next        = r_state;
        w_phys_we_next      = r_phys_we;
        w_phys_addr_next    = r_phys_addr;
        w_phys_data_next    = r_phys_data;
        w_phys_byte_en_next = r_phys_byte_en;
        w_hi_en_next        = r_hi_en;

        if (w_beat_done && (r_state == ST_BEAT0) && (r_hi_en != 4'b0000)) begin
            // Second beat of a split store; word address wraps modulo 2^30.
            w_state_next        = ST_BEAT1;
            w_phys_addr_next    = r_phys_addr + 30'd1;
            w_phys_byte_en_next = r_hi_en;
        end else if (w_load) begin
            // New store, either from IDLE or chained after a final beat.
            w_state_next        = ST_BEAT0;
            w_phys_we_next      = 1'b1;
            w_phys_addr_next    = bus.req_addr[31:2];
            w_phys_data_next    = w_rot_data;
            w_phys_byte_en_next = w_wide_mask[3:0];
            w_hi_en_next        = w_wide_mask[7:4];
        end else if (w_beat_done) begin
            w_state_next   = ST_IDLE;
            w_phys_we_next = 1'b0;
        end
    end

    assign w_size_err_next = w_accept && w_size_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_phys_we      <= 1'b0;
            r_phys_addr    <= 30'd0;
            r_phys_data    <= 32'd0;
            r_phys_byte_en <= 4'b0000;
            r_hi_en        <= 4'b0000;
            r_size_err     <= 1'b0;
        end else if (clk_enable) begin
            r_state        <= w_state_next;
            r_phys_we      <= w_phys_we_next;
            r_phys_addr    <= w_phys_addr_next;
            r_phys_data    <= w_phys_data_next;
            r_phys_byte_en <= w_phys_byte_en_next;
            r_hi_en        <= w_hi_en_next;
            r_size_err     <= w_size_err_next;
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.phys_we      = r_phys_we;
    assign bus.phys_addr    = r_phys_addr;
    assign bus.phys_data    = r_phys_data;
    assign bus.phys_byte_en = r_phys_byte_en;
    assign bus.size_err     = r_size_err;

endmodule

// File: tb/tb_mmu_store_encode.sv
// -----------------------------------------------------------------------------
// tb_mmu_store_encode
// Directed stimulus with hand-computed expected beats pushed into a scoreboard
// queue; a negedge monitor pops and compares every completed write beat and
// every size_err pulse.
// -----------------------------------------------------------------------------
module tb_mmu_store_encode;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  en;
        logic [31:0] data;
    } beat_t;

    logic clk;
    logic rst_n;
    logic clk_enable;

    mmu_store_encode_if bus ();

    mmu_store_encode dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    int    checks = 0;
    int    errors = 0;
    int    err_exp = 0;
    beat_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_beat(input logic [29:0] a, input logic [3:0] e, input logic [31:0] d);
        beat_t b;
        b.addr = a; b.en = e; b.data = d;
        exp_q.push_back(b);
    endtask

    // Present a request, wait (bounded) for acceptance, return cycles waited.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                        output int waited);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_size  = s;
        forever begin
            @(negedge clk);
            if (bus.req_ready && clk_enable) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got no accept expected accept for addr 0x%08h", a);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        waited = n;
        $display("req addr=0x%08h data=0x%08h size=%0d waited=%0d", a, d, s, n);
    endtask

    // Scoreboard monitor: a beat completes at the next posedge when we/ready/enable hold.
    always @(negedge clk) begin
        if (rst_n && clk_enable) begin
            if (bus.phys_we && bus.phys_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {34'd0, bus.phys_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    $display("beat addr=0x%08h en=%b data=0x%08h", bus.phys_addr, bus.phys_byte_en, bus.phys_data);
                    check("beat_addr", {34'd0, bus.phys_addr}, {34'd0, b.addr});
                    check("beat_en",   {60'd0, bus.phys_byte_en}, {60'd0, b.en});
                    check("beat_data", {32'd0, bus.phys_data}, {32'd0, b.data});
                end
            end
            if (bus.size_err) begin
                $display("size_err pulse");
                check("size_err_expected", {63'd0, (err_exp > 0)}, 64'd1);
                if (err_exp > 0) err_exp--;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b1;
        clk_enable = 1'b1;
        bus.phys_ready = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr = 32'd0;
        bus.req_data = 32'd0;
        bus.req_size = 2'd0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_we",       {63'd0, bus.phys_we}, 64'd0);
        check("rst_addr",     {34'd0, bus.phys_addr}, 64'd0);
        check("rst_data",     {32'd0, bus.phys_data}, 64'd0);
        check("rst_en",       {60'd0, bus.phys_byte_en}, 64'd0);
        check("rst_size_err", {63'd0, bus.size_err}, 64'd0);
        check("rst_ready",    {63'd0, bus.req_ready}, 64'd1);
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        // Byte store into the top lane.
        exp_beat(30'h400, 4'b1000, 32'hAB00_0000);
        send(32'h0000_1003, 32'h0000_00AB, 2'b00, w);

        // Word store crossing a word boundary.
        exp_beat(30'h800, 4'b1110, 32'h3322_1144);
        exp_beat(30'h801, 4'b0001, 32'h3322_1144);
        send(32'h0000_2001, 32'h4433_2211, 2'b10, w);
        check("split_ready_low", {63'd0, bus.req_ready}, 64'd0);

        // Half store wrapping the address space.
        exp_beat(30'h3FFF_FFFF, 4'b1000, 32'hEF00_00BE);
        exp_beat(30'h0000_0000, 4'b0001, 32'hEF00_00BE);
        send(32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01, w);
        check("wrap_ready_low", {63'd0, bus.req_ready}, 64'd0);

        // Back-to-back aligned words, one accept per cycle.
        exp_beat(30'h40, 4'b1111, 32'h1111_1111);
        exp_beat(30'h41, 4'b1111, 32'h2222_2222);
        exp_beat(30'h42, 4'b1111, 32'h3333_3333);
        send(32'h0000_0100, 32'h1111_1111, 2'b10, w);
        send(32'h0000_0104, 32'h2222_2222, 2'b10, w);
        check("b2b_no_bubble_1", w, 64'd0);
        send(32'h0000_0108, 32'h3333_3333, 2'b10, w);
        check("b2b_no_bubble_2", w, 64'd0);

        // Memory stalls: beat held, request side blocked.
        bus.phys_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_we",    {63'd0, bus.phys_we}, 64'd1);
            check("hold_addr",  {34'd0, bus.phys_addr}, 64'h42);
            check("hold_en",    {60'd0, bus.phys_byte_en}, 64'hF);
            check("hold_data",  {32'd0, bus.phys_data}, 64'h3333_3333);
            check("hold_ready", {63'd0, bus.req_ready}, 64'd0);
        end
        @(posedge clk); #1;
        bus.phys_ready = 1'b1;
        @(posedge clk); #1;

        // Illegal size: accepted, no beat, one-cycle size_err.
        err_exp++;
        send(32'h0000_0010, 32'h0000_0001, 2'b11, w);
        check("illegal_size_err", {63'd0, bus.size_err}, 64'd1);
        check("illegal_no_we",    {63'd0, bus.phys_we}, 64'd0);
        @(posedge clk); #1;
        check("illegal_err_gone", {63'd0, bus.size_err}, 64'd0);

        // clk_enable low freezes BEAT1 of a split store.
        exp_beat(30'hC00, 4'b1100, 32'hCCDD_AABB);
        exp_beat(30'hC01, 4'b0011, 32'hCCDD_AABB);
        send(32'h0000_3002, 32'hAABB_CCDD, 2'b10, w);
        @(posedge clk); #1;
        clk_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("freeze_we",   {63'd0, bus.phys_we}, 64'd1);
            check("freeze_addr", {34'd0, bus.phys_addr}, 64'hC01);
            check("freeze_en",   {60'd0, bus.phys_byte_en}, 64'h3);
        end
        @(posedge clk); #1;
        clk_enable = 1'b1;
        @(posedge clk); #1;

        // Reset during BEAT1 drops the second beat.
        exp_beat(30'h1400, 4'b1000, 32'h7812_3456);
        send(32'h0000_5003, 32'h1234_5678, 2'b10, w);
        @(posedge clk); #1;
        check("pre_rst_we", {63'd0, bus.phys_we}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_we",    {63'd0, bus.phys_we}, 64'd0);
        check("async_rst_ready", {63'd0, bus.req_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", {63'd0, bus.req_ready}, 64'd1);
        check("post_rst_we",    {63'd0, bus.phys_we}, 64'd0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 64'd0);
        check("size_err_all_seen", err_exp, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
